// File: rtl/poly_eval.sv
// Serial-load Horner polynomial evaluator: c[DEGREE]..c[0] then x, one operand per go strobe.
// Define POLY_EVAL_SAT_EN for per-step saturation with a sticky ovf flag; otherwise modulo 2^WIDTH.
module poly_eval #(
   parameter int WIDTH  = 8,
   parameter int DEGREE = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             go_i,
   input  logic [WIDTH-1:0] data_in_i,
   output logic [WIDTH-1:0] data_result_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o
);
   localparam int NOPS = DEGREE + 2;
   localparam int IW   = $clog2(NOPS + 1);
   localparam int KW   = (DEGREE > 1) ? $clog2(DEGREE) : 1;

   typedef enum logic [1:0] {S_LOAD, S_LOAD_WAIT, S_CALC, S_DONE} state_t;

   state_t           state_q;
   logic [IW-1:0]    idx_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] ops_q [NOPS];
   logic [WIDTH-1:0] result_q;
   logic             busy_q, done_q, ovf_q;
   logic [WIDTH-1:0] x_op, ck;
   logic             step_ovf;

   // Slot 0 holds c[DEGREE], slot DEGREE holds c[0], the last slot holds x.
   assign x_op = ops_q[NOPS-1];

   always_comb begin
      ck = ops_q[DEGREE];
      for (int i = 0; i < DEGREE; i++)
         if (k_q == KW'(i)) ck = ops_q[DEGREE-i];
   end

`ifdef POLY_EVAL_SAT_EN
   logic [2*WIDTH:0] full;
   always_comb begin
      full     = (2*WIDTH+1)'(acc_q) * (2*WIDTH+1)'(x_op) + (2*WIDTH+1)'(ck);
      step_ovf = |full[2*WIDTH:WIDTH];
      acc_d    = step_ovf ? '1 : full[WIDTH-1:0];
   end
`else
   assign step_ovf = 1'b0;
   assign acc_d    = acc_q * x_op + ck;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_LOAD;
         idx_q    <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < NOPS; i++) ops_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (go_i) begin
                  for (int i = 0; i < NOPS; i++)
                     if (idx_q == IW'(i)) ops_q[i] <= data_in_i;
                  idx_q   <= idx_q + IW'(1);
                  state_q <= S_LOAD_WAIT;
               end
            end
            S_LOAD_WAIT: begin
               // Wait for go to fall so a long strobe captures only one operand.
               if (!go_i) begin
                  if (idx_q == IW'(NOPS)) begin
                     state_q <= S_CALC;
                     acc_q   <= ops_q[0];
                     k_q     <= KW'(DEGREE-1);
                     busy_q  <= 1'b1;
                     ovf_q   <= 1'b0;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               ovf_q <= ovf_q | step_ovf;
               if (k_q == '0) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  result_q <= acc_d;
                  done_q   <= 1'b1;
               end else begin
                  k_q <= k_q - KW'(1);
               end
            end
            S_DONE: begin
               state_q <= S_LOAD;
               idx_q   <= '0;
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign data_result_o = result_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign ovf_o         = ovf_q;
endmodule
